// File: rtl/ws2812_out.sv
// WS2812 NRZ serialiser: fetches WORD_COUNT words from sram_bus and repeats the frame after a latch gap.
// Define WS2812_OUT_BYTE_SWAP_EN to send each word low byte first.
module ws2812_out #(
    parameter int ADDRESS_BUS_WIDTH = 14,
    parameter int WORD_COUNT        = 96,
    parameter int START_ADDRESS     = 0,
    parameter int BIT_CYCLES        = 30,
    parameter int T0H_CYCLES        = 10,
    parameter int T1H_CYCLES        = 19,
    parameter int LATCH_CYCLES      = 6720
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [ADDRESS_BUS_WIDTH-1:0] read_address,
    output logic                         read_strobe,
    input  logic [15:0]                  read_data,
    input  logic                         read_finished_strobe,
    output logic                         data_out,
    output logic                         start_read_strobe
);
    localparam int BW = $clog2(BIT_CYCLES + 1);
    localparam int LW = $clog2(LATCH_CYCLES + 1);
    localparam logic [ADDRESS_BUS_WIDTH-1:0] START = START_ADDRESS[ADDRESS_BUS_WIDTH-1:0];
    localparam logic [ADDRESS_BUS_WIDTH:0]   WC    = WORD_COUNT[ADDRESS_BUS_WIDTH:0];
    localparam logic [BW-1:0]                LAST_CYC  = BW'(BIT_CYCLES - 1);
    localparam logic [LW-1:0]                LATCH_END = LW'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {LATCH, FETCH, SHIFT, STALL} state_t;

    state_t                     state;
    logic [LW-1:0]              latch_cnt;
    logic [BW-1:0]              bit_cnt;
    logic [3:0]                 bit_idx;
    logic [15:0]                shift_reg;
    logic [15:0]                buf_word;
    logic                       buf_vld;
    logic                       rd_pend;
    logic [ADDRESS_BUS_WIDTH:0] word_idx;

    logic        accept, launch, word_end, load, issue;
    logic [15:0] load_word;

    // Words are reordered on load so the shifter always walks bit 15 down to 0.
    function automatic logic [15:0] order_word(input logic [15:0] d);
`ifdef WS2812_OUT_BYTE_SWAP_EN
        return {d[7:0], d[15:8]};
`else
        return d;
`endif
    endfunction

    function automatic logic high_at(input logic b, input logic [BW-1:0] cnt);
        return int'(cnt) < (b ? T1H_CYCLES : T0H_CYCLES);
    endfunction

    always_comb begin
        accept    = read_finished_strobe && rd_pend;
        launch    = (state == LATCH) && (latch_cnt == LATCH_END);
        word_end  = (state == SHIFT) && (bit_cnt == LAST_CYC) && (bit_idx == 4'd0);
        load      = 1'b0;
        load_word = order_word(read_data);
        case (state)
            FETCH, STALL: load = accept;
            SHIFT: begin
                // A completion landing on the last cycle of bit 0 feeds the shifter directly.
                if (word_end && accept) begin
                    load = 1'b1;
                end else if (word_end && buf_vld) begin
                    load      = 1'b1;
                    load_word = order_word(buf_word);
                end
            end
            default: ;
        endcase
        issue = load && (word_idx < WC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= LATCH;
            latch_cnt         <= '0;
            bit_cnt           <= '0;
            bit_idx           <= 4'd0;
            shift_reg         <= '0;
            buf_word          <= '0;
            buf_vld           <= 1'b0;
            rd_pend           <= 1'b0;
            word_idx          <= '0;
            read_address      <= START;
            read_strobe       <= 1'b0;
            start_read_strobe <= 1'b0;
            data_out          <= 1'b0;
        end else begin
            read_strobe       <= launch || issue;
            start_read_strobe <= launch;

            if (launch) begin
                read_address <= START;
                word_idx     <= {{ADDRESS_BUS_WIDTH{1'b0}}, 1'b1};
                rd_pend      <= 1'b1;
            end else if (issue) begin
                read_address <= read_address + 1'b1;
                word_idx     <= word_idx + 1'b1;
                rd_pend      <= 1'b1;
            end else if (accept) begin
                rd_pend      <= 1'b0;
            end

            if (accept && !load) begin
                buf_word <= read_data;
                buf_vld  <= 1'b1;
            end else if (load) begin
                buf_vld  <= 1'b0;
            end

            if (load) begin
                state     <= SHIFT;
                shift_reg <= load_word;
                bit_idx   <= 4'd15;
                bit_cnt   <= '0;
                data_out  <= high_at(load_word[15], '0);
            end else begin
                case (state)
                    LATCH: begin
                        data_out  <= 1'b0;
                        latch_cnt <= latch_cnt + 1'b1;
                        if (launch) state <= FETCH;
                    end
                    FETCH, STALL: data_out <= 1'b0;
                    SHIFT: begin
                        if (bit_cnt == LAST_CYC) begin
                            bit_cnt <= '0;
                            if (bit_idx != 4'd0) begin
                                bit_idx  <= bit_idx - 4'd1;
                                data_out <= high_at(shift_reg[bit_idx - 4'd1], '0);
                            end else begin
                                data_out <= 1'b0;
                                if (rd_pend) begin
                                    state <= STALL;
                                end else begin
                                    state     <= LATCH;
                                    latch_cnt <= '0;
                                end
                            end
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            data_out <= high_at(shift_reg[bit_idx], bit_cnt + 1'b1);
                        end
                    end
                    default: state <= LATCH;
                endcase
            end
        end
    end
endmodule
